// File: rtl/ps2_key_event_queue.sv
// PS/2 keyboard receiver: E0/F0 prefix decode into key events, FIFO queue, press/release counters.
// Latency: event pushed one cycle after the stop-bit falling edge; visible on evt_* one cycle later.
// Backpressure: evt_valid/evt_ready; full FIFO drops new events and sets sticky overflow. Option: TYPEMATIC_FILTER_EN.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic [CNT_W-1:0] release_cnt,
  output logic             overflow,
  output logic             frame_err
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] EXT_PFX = 8'hE0;
  localparam logic [7:0] BRK_PFX = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fe;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fe    = clk_prev & ~clk_s;

  state_t         state;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic [7:0]     rx_byte;
  logic           par_bit;
  logic           byte_ok;
  logic [WDW-1:0] wd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      rx_byte   <= 8'd0;
      par_bit   <= 1'b0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      wd        <= '0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fe) wd <= '0;
      else                     wd <= wd + 1'b1;
      if (fe) begin
        case (state)
          IDLE: if (!dat_s) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dat_s && (^{shreg, par_bit})) begin
              byte_ok <= 1'b1;
              rx_byte <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (state != IDLE && wd == WDW'(TIMEOUT_CYC - 1)) begin
        // Stalled partial frame: abandon it so the next start bit resynchronises.
        state     <= IDLE;
        frame_err <= 1'b1;
        wd        <= '0;
      end
    end
  end

  logic          ext_f, brk_f;
  logic          is_evt, suppress, emit, pop, full, wr_en;
  evt_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  assign is_evt = byte_ok && rx_byte != EXT_PFX && rx_byte != BRK_PFX;

`ifdef TYPEMATIC_FILTER_EN
  logic       held;
  logic [8:0] last_make;
  assign suppress = is_evt && !brk_f && held && last_make == {ext_f, rx_byte};

  always_ff @(posedge clock) begin
    if (reset) begin
      held      <= 1'b0;
      last_make <= 9'd0;
    end else if (is_evt) begin
      if (brk_f) begin
        if (last_make == {ext_f, rx_byte}) held <= 1'b0;
      end else if (!suppress) begin
        last_make <= {ext_f, rx_byte};
        held      <= 1'b1;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign emit      = is_evt && !suppress;
  assign evt_valid = count != '0;
  assign pop       = evt_valid && evt_ready;
  assign full      = count == (PW+1)'(FIFO_DEPTH);
  assign wr_en     = emit && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
      press_cnt   <= '0;
      release_cnt <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (frame_err) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_ok) begin
        if (rx_byte == EXT_PFX)      ext_f <= 1'b1;
        else if (rx_byte == BRK_PFX) brk_f <= 1'b1;
        else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
      // Counters track decoded keys, including ones the full FIFO has to drop.
      if (emit) begin
        if (brk_f) release_cnt <= release_cnt + 1'b1;
        else       press_cnt   <= press_cnt + 1'b1;
      end
      if (emit && full && !pop) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= '{code: rx_byte, brk: brk_f, ext: ext_f};
  end

  evt_t head;
  assign head      = evt_valid ? mem[rd_ptr] : '0;
  assign evt_code  = head.code;
  assign evt_break = head.brk;
  assign evt_ext   = head.ext;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: vector table, FIFO/timeout corner sequences, randomized frames vs a byte-level model.
module tb_ps2_key_event_queue;
  localparam int TO = 300;
  localparam int H  = 16;
  localparam int FD = 8;

  logic clock = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0;
  logic evt_valid, evt_break, evt_ext, overflow, frame_err;
  logic [7:0] evt_code, press_cnt, release_cnt;

  ps2_key_event_queue #(.FIFO_DEPTH(FD), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .press_cnt(press_cnt),
    .release_cnt(release_cnt), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int cyc = 0, err_cnt = 0, t_rise = 0, t_stop = 0;
  logic pv = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (evt_valid && !pv) t_rise <= cyc;
    pv <= evt_valid;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Bits go out LSB first; optional pop lands on the same cycle as the event push.
  task automatic send_bits(input logic [10:0] f, input int n, input bit tpop);
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (H) @(posedge clock);
      #1 ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      if (tpop && i == 10) begin
        repeat (3) @(posedge clock);
        #1 evt_ready = 1'b1;
        @(posedge clock);
        #1 evt_ready = 1'b0;
        repeat (H - 4) @(posedge clock);
      end else begin
        repeat (H) @(posedge clock);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b0), 11, 1'b0);
  endtask

  task automatic pop_check(input string nm, input logic [7:0] c, input bit b, input bit e);
    @(negedge clock);
    chk({nm, "_valid"}, evt_valid, 1);
    chk({nm, "_code"}, evt_code, c);
    chk({nm, "_break"}, evt_break, b);
    chk({nm, "_ext"}, evt_ext, e);
    evt_ready = 1'b1;
    @(posedge clock);
    #1 evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clock);
    chk({nm, "_valid"}, evt_valid, 0);
    chk({nm, "_code"}, evt_code, 0);
    chk({nm, "_flags"}, {evt_break, evt_ext, overflow, frame_err}, 0);
    chk({nm, "_cnts"}, {press_cnt, release_cnt}, 0);
  endtask

  typedef struct {
    logic [7:0] b; bit bad_par; bit bad_stop;
    bit exp_evt; logic [7:0] code; bit brk; bit ext; bit exp_err;
  } vec_t;
  vec_t tv[14];

  typedef struct { logic [7:0] c; bit b; bit e; } ev_t;
  ev_t mq[$];
  bit m_ext, m_brk, m_held;
  logic [8:0] m_last;
  logic [7:0] m_press, m_rel;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    bit keep;
    keep = 1'b1;
    if (!ok) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
`ifdef TYPEMATIC_FILTER_EN
      if (!m_brk && m_held && m_last == {m_ext, b}) keep = 1'b0;
      else if (m_brk && m_last == {m_ext, b}) m_held = 1'b0;
      else if (!m_brk) begin m_last = {m_ext, b}; m_held = 1'b1; end
`endif
      if (keep) begin
        mq.push_back('{b, m_brk, m_ext});
        if (m_brk) m_rel++; else m_press++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  initial begin
    int e0;
    tv[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0};
    tv[1]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[2]  = '{8'h1C, 0, 0, 1, 8'h1C, 1, 0, 0};
    tv[3]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[4]  = '{8'h75, 0, 0, 1, 8'h75, 0, 1, 0};
    tv[5]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[6]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[7]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0};
    tv[8]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1};
    tv[9]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tv[10] = '{8'h22, 1, 0, 0, 8'h00, 0, 0, 1};
    tv[11] = '{8'h22, 0, 0, 1, 8'h22, 0, 0, 0};
    tv[12] = '{8'h33, 0, 1, 0, 8'h00, 0, 0, 1};
    tv[13] = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0};

    do_reset();
    chk_idle("reset");

    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      send_bits(mk(tv[i].b, tv[i].bad_par, tv[i].bad_stop), 11, 1'b0);
      if (i == 0) chk("latency", t_rise - t_stop, 4);
      @(negedge clock);
      chk($sformatf("v%0d_err", i), err_cnt - e0, tv[i].exp_err);
      if (tv[i].exp_evt) pop_check($sformatf("v%0d", i), tv[i].code, tv[i].brk, tv[i].ext);
      else chk($sformatf("v%0d_noevt", i), evt_valid, 0);
    end
    @(negedge clock);
    chk("tab_press_cnt", press_cnt, 4);
    chk("tab_release_cnt", release_cnt, 2);

    // Stall after the 4th data bit until the watchdog fires.
    e0 = err_cnt;
    send_bits(mk(8'h1B, 0, 0), 5, 1'b0);
    repeat (TO + 40) @(posedge clock);
    @(negedge clock);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_noevt", evt_valid, 0);
    send(8'h1B);
    pop_check("after_timeout", 8'h1B, 0, 0);

    // Reset in the middle of a frame.
    send(8'h44);
    send_bits(mk(8'h2A, 0, 0), 6, 1'b0);
    do_reset();
    chk_idle("midreset");
    send(8'h1C);
    pop_check("after_midreset", 8'h1C, 0, 0);

    // FIFO fill, full push+pop, overflow drop.
    do_reset();
    for (int i = 0; i < FD; i++) send(8'h30 + 8'(i));
    @(negedge clock);
    chk("full_no_ovf", overflow, 0);
    chk("full_press_cnt", press_cnt, FD);
    send_bits(mk(8'h38, 0, 0), 11, 1'b1);
    @(negedge clock);
    chk("pushpop_no_ovf", overflow, 0);
    send(8'h39);
    @(negedge clock);
    chk("ovf_set", overflow, 1);
    chk("ovf_press_cnt", press_cnt, FD + 2);
    for (int i = 0; i < FD; i++) pop_check($sformatf("drain%0d", i), 8'h31 + 8'(i), 0, 0);
    @(negedge clock);
    chk("drained_empty", evt_valid, 0);
    evt_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 evt_ready = 1'b0;
    @(negedge clock);
    chk("empty_pop_valid", evt_valid, 0);
    chk("empty_pop_code", evt_code, 0);
    chk("ovf_sticky", overflow, 1);

    // Typematic repeats.
    do_reset();
    send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
`ifdef TYPEMATIC_FILTER_EN
    pop_check("typ_p0", 8'h1B, 0, 0);
    @(negedge clock);
    chk("typ_press_cnt", press_cnt, 1);
`else
    for (int i = 0; i < 3; i++) pop_check($sformatf("typ_p%0d", i), 8'h1B, 0, 0);
    @(negedge clock);
    chk("typ_press_cnt", press_cnt, 3);
`endif
    pop_check("typ_rel", 8'h1B, 1, 0);
    @(negedge clock);
    chk("typ_release_cnt", release_cnt, 1);
    chk("typ_empty", evt_valid, 0);

    // Randomized frames against the byte-level model.
    do_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_last = '0; m_press = '0; m_rel = '0;
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] b;
      bit bad;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'h10 + 8'($urandom_range(0, 3));
      bad = ($urandom_range(0, 7) == 0);
      e0 = err_cnt;
      send_bits(mk(b, bad, 1'b0), 11, 1'b0);
      model_byte(b, !bad);
      @(negedge clock);
      chk($sformatf("rnd%0d_err", n), err_cnt - e0, bad);
      while (mq.size() > 0) begin
        ev_t e;
        e = mq.pop_front();
        pop_check($sformatf("rnd%0d", n), e.c, e.b, e.e);
      end
      @(negedge clock);
      chk($sformatf("rnd%0d_empty", n), evt_valid, 0);
    end
    chk("rnd_press_cnt", press_cnt, m_press);
    chk("rnd_release_cnt", release_cnt, m_rel);
    chk("rnd_no_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
